// File: rtl/i2c_bus_pkg.sv
// i2c_bus_pkg: shared defaults and the event bundle consumed by the I2C controller core.
package i2c_bus_pkg;

    localparam int FILT_LEN_DEF = 4;
    localparam int TO_W_DEF     = 16;

    typedef struct packed {
        logic scl_re;
        logic scl_fe;
        logic start;
        logic stop;
        logic timeout;
    } i2c_bus_evt_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: 2-flop synchroniser plus persistence filter for one I2C line.
module i2c_glitch_filter
    import i2c_bus_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic raw_i,
    output logic level_o,
    output logic level_nxt_o
);

    localparam logic [7:0] LP_LAST = 8'(FILT_LEN - 1);

    logic [1:0] r_sync;
    logic       r_level;
    logic [7:0] r_cnt;
    logic       w_diff;
    logic       w_take;

    assign w_diff      = r_sync[1] ^ r_level;
    assign w_take      = w_diff && (r_cnt == LP_LAST);
    // Next level is exported so the top can form edge pulses coincident with the level change.
    assign level_nxt_o = enable_i ? (w_take ? r_sync[1] : r_level) : 1'b1;
    assign level_o     = r_level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync  <= enable_i ? {r_sync[0], raw_i} : 2'b11;
            r_level <= level_nxt_o;
            r_cnt   <= (enable_i && w_diff && !w_take) ? r_cnt + 8'd1 : '0;
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: conditions raw SCL/SDA and reports edges, START/STOP, bus busy and SCL-low timeout.
module i2c_bus_monitor
    import i2c_bus_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            scl_i,
    input  logic            sda_i,
    input  logic [TO_W-1:0] timeout_limit_i,
    output logic            scl_o,
    output logic            sda_o,
    output logic            scl_re_o,
    output logic            scl_fe_o,
    output logic            start_det_o,
    output logic            stop_det_o,
    output logic            bus_busy_o,
    output logic            timeout_o
);

    logic            w_scl;
    logic            w_scl_nxt;
    logic            w_sda;
    logic            w_sda_nxt;
    i2c_bus_evt_t    w_evt_nxt;
    i2c_bus_evt_t    r_evt;
    logic            r_busy;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_done;
    logic [TO_W:0]   w_to_inc;
    logic            w_to_run;
    logic            w_to_fire;
    logic            w_scl_hi;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .raw_i       (scl_i),
        .level_o     (w_scl),
        .level_nxt_o (w_scl_nxt)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .raw_i       (sda_i),
        .level_o     (w_sda),
        .level_nxt_o (w_sda_nxt)
    );

    // SCL high before and after the SDA change; a coincident SCL edge rules out START/STOP.
    assign w_scl_hi  = w_scl & w_scl_nxt;
    assign w_to_inc  = {1'b0, r_to_cnt} + 1'b1;
    assign w_to_run  = !w_scl && (timeout_limit_i != '0) && !r_to_done;
    assign w_to_fire = w_to_run && (w_to_inc >= {1'b0, timeout_limit_i});

    always_comb begin
        w_evt_nxt.scl_re  = ~w_scl & w_scl_nxt;
        w_evt_nxt.scl_fe  = w_scl & ~w_scl_nxt;
        w_evt_nxt.start   = w_scl_hi & w_sda & ~w_sda_nxt;
        w_evt_nxt.stop    = w_scl_hi & ~w_sda & w_sda_nxt;
        w_evt_nxt.timeout = w_to_fire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt     <= '0;
            r_busy    <= 1'b0;
            r_to_cnt  <= '0;
            r_to_done <= 1'b0;
        end else if (!enable_i) begin
            r_evt     <= '0;
            r_busy    <= 1'b0;
            r_to_cnt  <= '0;
            r_to_done <= 1'b0;
        end else begin
            r_evt     <= w_evt_nxt;
            r_busy    <= w_evt_nxt.start ? 1'b1 : (w_evt_nxt.stop ? 1'b0 : r_busy);
            r_to_cnt  <= w_scl ? '0 : (w_to_run ? w_to_inc[TO_W-1:0] : r_to_cnt);
            r_to_done <= w_scl ? 1'b0 : (r_to_done | w_to_fire);
        end
    end

    assign scl_o       = w_scl;
    assign sda_o       = w_sda;
    assign scl_re_o    = r_evt.scl_re;
    assign scl_fe_o    = r_evt.scl_fe;
    assign start_det_o = r_evt.start;
    assign stop_det_o  = r_evt.stop;
    assign bus_busy_o  = r_busy;
    assign timeout_o   = r_evt.timeout;

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Front-end conditioning stage between the I2C pads and the I2C controller core. It synchronises and deglitches raw `scl`/`sda`, produces clean filtered levels and edge pulses, detects START/STOP conditions, tracks bus-busy state, and flags SCL-stuck-low timeouts. Its filtered outputs feed the core's `scl_i`/`sda_i`, and its event pulses are available to the core for arbitration and interrupt logic.

## Interface
Parameters:
- `FILT_LEN`, default 4: number of consecutive cycles a new synchronised level must persist before it is accepted; legal range 1..255.
- `TO_W`, default 16: width of the timeout counter and limit.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  block enable; while low, all state is held at reset values (synchronous clear).
- `scl_i`  in  1  raw SCL from pad; asynchronous to `clk_i`.
- `sda_i`  in  1  raw SDA from pad; asynchronous to `clk_i`.
- `timeout_limit_i`  in  TO_W  SCL-low timeout in cycles; 0 disables the timeout.
- `scl_o`  out  1  filtered SCL.
- `sda_o`  out  1  filtered SDA.
- `scl_re_o` / `scl_fe_o`  out  1  one-cycle pulses on filtered SCL rise/fall.
- `start_det_o`  out  1  one-cycle pulse on START or repeated START.
- `stop_det_o`  out  1  one-cycle pulse on STOP.
- `bus_busy_o`  out  1  high from START until STOP.
- `timeout_o`  out  1  one-cycle pulse when SCL has been low for `timeout_limit_i` cycles.

## Operation
- Reset / `enable_i`=0 values: `scl_o`=1, `sda_o`=1, `bus_busy_o`=0, all pulses 0. Synchroniser flops reset to 1. All counters reset to 0.
- Synchroniser: a 2-flop synchroniser per line.
- Filter, per line:
  - A counter `cnt` increments while the synchronised level differs from the filtered level.
  - When it differs and `cnt`==FILT_LEN-1, the filtered level takes the new value and `cnt` clears.
  - Any cycle where the synchronised level equals the filtered level clears `cnt`.
  - A pulse shorter than FILT_LEN cycles is therefore never propagated.
- Edge pulses: asserted in the first cycle the filtered level shows its new value.
- START: filtered SDA falls while filtered SCL is 1 in both the previous and the current cycle. Sets `bus_busy_o`. START while busy is a repeated START: the pulse fires and busy stays 1.
- STOP: filtered SDA rises while filtered SCL is 1 in both the previous and the current cycle. Clears `bus_busy_o`. STOP while not busy still pulses.
- Simultaneous filtered SCL and SDA change in the same cycle: no START/STOP is detected; only the SCL edge pulse fires.
- Timeout:
  - The counter increments each cycle filtered SCL is 0 and `timeout_limit_i`≠0.
  - When it reaches `timeout_limit_i`, `timeout_o` pulses once and the counter saturates. There are no further pulses until SCL returns to 1, which clears the counter.
  - A limit change mid-count takes effect on the next comparison.
  - `bus_busy_o` is not affected by timeout.

## Timing
- Latency from a raw input change to the filtered output is FILT_LEN+2 cycles: 2 synchroniser cycles plus FILT_LEN filter cycles.
- All outputs are registered; pulses are computed from next-state and are coincident with the level change.
- `start_det_o`, `stop_det_o` and `bus_busy_o` update in the same cycle as the SDA transition on `sda_o`.
- `timeout_o` is asserted in the cycle where the count equals the limit: exactly `timeout_limit_i` cycles after `scl_fe_o`.
- Asynchronous reset mid-transfer: outputs go to reset values immediately. After release, the lines must be stable for FILT_LEN+2 cycles before any change is reported. A bus that is low at release yields `scl_fe_o`/`sda` falls, but no START if SCL is also low.
- Deassertion of `enable_i` clears all state on the next edge, with no pulses.

## Structure
- Shared package `i2c_bus_pkg` holds:
  - the `FILT_LEN` and `TO_W` defaults;
  - a packed struct `i2c_bus_evt_t` {scl_re, scl_fe, start, stop, timeout} for the core to consume.
- Sub-module `i2c_glitch_filter` (synchroniser plus persistence counter, parameterised by FILT_LEN) is instantiated once per line.
- The top level holds the START/STOP detector, the busy flag and the timeout counter.

## Test plan
- Glitch rejection, FILT_LEN=4: SDA low pulse of 3 cycles with SCL=1 -> `sda_o` stays 1, no `start_det_o`. A 4-cycle pulse -> `sda_o` goes 0 at cycle 6, plus `start_det_o` for 1 cycle and `bus_busy_o`=1.
- Full frame: START, 9 SCL clocks (16-cycle periods), repeated START, STOP -> 9 `scl_re_o` pulses, 2 `start_det_o`, 1 `stop_det_o`, busy 1 to 0 exactly at STOP.
- Simultaneous edge: SCL and SDA fall in the same cycle -> `scl_fe_o`=1, `start_det_o`=0, busy unchanged.
- Timeout, limit=100: hold SCL low for 150 cycles -> a single `timeout_o` pulse exactly 100 cycles after `scl_fe_o`; release and re-hold -> a second pulse. Limit=0 -> no pulse.
- Reset/enable: assert `rst_ni`=0 mid-byte -> all outputs at reset values asynchronously. Drop `enable_i` while busy -> busy 0 next cycle, no pulses.
